// File: rtl/vedic_mult_serial.sv
// Serial Urdhva-Tiryagbhyam (vertical-and-crosswise) unsigned multiplier.
// Operands are captured on a valid/ready handshake. One product column is
// resolved per clock: the column parity becomes the product bit, and the
// remainder of the column sum carries into the next column. The finished
// product is held under a valid/ready handshake until the consumer takes it.
module vedic_mult_serial #(
    parameter int N  = 4,
    parameter int CW = $clog2(N) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int COLW = $clog2(2*N-1);
    localparam int IW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [COLW-1:0] LAST_COL = COLW'(2*N-2);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     a_r, b_r;
    logic [CW-1:0]    carry_q;
    logic [CW-1:0]    col_sum;
    logic [COLW-1:0]  col_q;
    logic [2*N-1:0]   product_q;
    logic [IW-1:0]    jdx;
    logic             accept;

    assign accept  = in_valid && in_ready;
    assign product = product_q;

    // Column sum: incoming carry plus every crosswise a[i]&b[j] with i+j == col.
    always_comb begin
        col_sum = carry_q;
        jdx     = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(col_q) >= i && int'(col_q) - i < N) begin
                jdx     = IW'(int'(col_q) - i);
                col_sum = col_sum + CW'(a_r[i] & b_r[jdx]);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic and handshake outputs decoded from the current state.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = COMPUTE;
            end
            COMPUTE: begin
                busy = 1'b1;
                if (col_q == LAST_COL) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, then fill in one product bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r       <= '0;
            b_r       <= '0;
            carry_q   <= '0;
            col_q     <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_r       <= a;
                        b_r       <= b;
                        carry_q   <= '0;
                        col_q     <= '0;
                        product_q <= '0;
                    end
                end
                COMPUTE: begin
                    product_q[col_q] <= col_sum[0];
                    carry_q          <= col_sum >> 1;
                    col_q            <= col_q + 1'b1;
                    // The last column's carry is at most 1 and becomes the MSB.
                    if (col_q == LAST_COL) product_q[2*N-1] <= col_sum[1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_mult_serial.sv
// Directed bench for vedic_mult_serial: N=4 instance for handshake, timing,
// backpressure, reset and exhaustive products; N=8 instance for spot checks.
module tb_vedic_mult_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, out_ready;
    logic [3:0] a, b;
    logic       in_ready, out_valid, busy;
    logic [7:0] product;

    logic        in_valid8, out_ready8;
    logic [7:0]  a8, b8;
    logic        in_ready8, out_valid8, busy8;
    logic [15:0] product8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vedic_mult_serial #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    vedic_mult_serial #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .product(product8), .busy(busy8)
    );

    // Present operands for one cycle; returns #1 after the accepting edge.
    task automatic start4(input logic [3:0] x, input logic [3:0] y);
        a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Advance until out_valid, bounded; reports cycles waited and busy samples.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0; busy_cnt = 0;
        while (!out_valid && lat < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        checks++; if (product !== 8'h00) begin errors++; $display("FAIL reset_product got=%h exp=00", product); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_accept;
        int lat, bc;
        out_ready = 1'b1;
        start4(4'd3, 4'd5);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL accept_in_ready got=%b exp=0", in_ready); end
        wait_done(lat, bc);
        checks++; if (lat != 7) begin errors++; $display("FAIL accept_latency got=%0d exp=7", lat); end
        checks++; if (bc != 7) begin errors++; $display("FAIL accept_busy_cycles got=%0d exp=7", bc); end
        checks++; if (product !== 8'h0F) begin errors++; $display("FAIL accept_product got=%h exp=0f", product); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL accept_handoff got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
    endtask

    task automatic test_max;
        int lat, bc;
        start4(4'd15, 4'd15);
        wait_done(lat, bc);
        checks++; if (lat != 7) begin errors++; $display("FAIL max_latency got=%0d exp=7", lat); end
        checks++; if (product !== 8'hE1) begin errors++; $display("FAIL max_product got=%h exp=e1", product); end
        checks++; if (product[7] !== 1'b1) begin errors++; $display("FAIL max_msb got=%b exp=1", product[7]); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero;
        int lat, bc;
        start4(4'd0, 4'd9);
        wait_done(lat, bc);
        checks++; if (out_valid !== 1'b1 || lat != 7) begin
            errors++; $display("FAIL zero_valid got ov=%b lat=%0d exp ov=1 lat=7", out_valid, lat); end
        checks++; if (product !== 8'h00) begin errors++; $display("FAIL zero_product got=%h exp=00", product); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        int lat, bc;
        out_ready = 1'b0;
        start4(4'd11, 4'd13);
        wait_done(lat, bc);
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1 || product !== 8'h8F || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d] got ov=%b p=%h ir=%b exp ov=1 p=8f ir=0", k, out_valid, product, in_ready); end
            @(posedge clk); #1;
        end
        checks++; if (out_valid !== 1'b1 || product !== 8'h8F) begin
            errors++; $display("FAIL bp_hold_end got ov=%b p=%h exp ov=1 p=8f", out_valid, product); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
    endtask

    task automatic test_busy_inputs;
        int lat, bc;
        out_ready = 1'b0;
        start4(4'd2, 4'd6);
        @(posedge clk); #1;
        a = 4'd7; b = 4'd7; in_valid = 1'b1;
        wait_done(lat, bc);
        checks++; if (product !== 8'h0C || lat != 6) begin
            errors++; $display("FAIL busy_in_product got=%h lat=%0d exp=0c lat=6", product, lat); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL busy_in_idle got ir=%b busy=%b exp ir=1 busy=0", in_ready, busy); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_accept got busy=%b exp=1", busy); end
        wait_done(lat, bc);
        checks++; if (product !== 8'h31) begin errors++; $display("FAIL busy_in_second got=%h exp=31", product); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        start4(4'd13, 4'd11);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++; if (product !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs got p=%h ov=%b busy=%b exp p=00 ov=0 busy=0", product, out_valid, busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_release got ir=%b busy=%b ov=%b exp ir=1 busy=0 ov=0", in_ready, busy, out_valid); end
    endtask

    task automatic test_exhaustive;
        int lat, bc, stall;
        logic [7:0] exp;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                stall = $urandom_range(0, 2);
                out_ready = (stall == 0);
                exp = 8'(ai * bi);
                start4(4'(ai), 4'(bi));
                wait_done(lat, bc);
                checks++; if (out_valid !== 1'b1 || product !== exp) begin
                    errors++; $display("FAIL exh %0d*%0d got ov=%b p=%h exp p=%h", ai, bi, out_valid, product, exp); end
                repeat (stall) begin @(posedge clk); #1; end
                out_ready = 1'b1;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_n8;
        logic [7:0]  xa [2];
        logic [7:0]  xb [2];
        logic [15:0] xp [2];
        int lat;
        xa[0] = 8'd255; xb[0] = 8'd255; xp[0] = 16'hFE01;
        xa[1] = 8'd128; xb[1] = 8'd2;   xp[1] = 16'h0100;
        out_ready8 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            a8 = xa[k]; b8 = xb[k]; in_valid8 = 1'b1;
            @(posedge clk); #1;
            in_valid8 = 1'b0;
            lat = 0;
            while (!out_valid8 && lat < 40) begin @(posedge clk); #1; lat++; end
            checks++; if (product8 !== xp[k] || lat != 15) begin
                errors++; $display("FAIL n8[%0d] got p=%h lat=%0d exp p=%h lat=15", k, product8, lat, xp[k]); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_accept;
        test_max;
        test_zero;
        test_backpressure;
        test_busy_inputs;
        test_reset_mid;
        test_exhaustive;
        test_n8;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
